// File: rtl/iob_uart_txbuf_pkg.sv
// Shared definitions for the UART transmit buffer.
//   state_e           : launch FSM encoding (idle / wait for core busy / wait for core done)
//   DefaultDataW      : default entry width
//   DefaultDepthLog2  : default log2 of FIFO depth (legal range 1..8)
package iob_uart_txbuf_pkg;

    localparam int unsigned DefaultDataW     = 8;
    localparam int unsigned DefaultDepthLog2 = 4;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitBusy = 2'd1,
        StWaitDone = 2'd2
    } state_e;

endpackage

// File: rtl/iob_uart_txbuf_if.sv
// Bus between the register file / UART core and the transmit buffer.
//   wr_en_i, wr_data_i : push strobe and byte from the register file
//   tx_en_i            : transmit enable, gates new launches only
//   tx_ready_i         : core idle / ready-for-byte flag
//   clr_ovf_i          : clears the sticky overflow flag
//   tx_data_o          : byte presented to the core
//   tx_write_o         : one-cycle data write strobe to the core
//   full_o, empty_o    : registered FIFO occupancy flags
//   level_o            : registered entry count, 0..2**DEPTH_LOG2
//   overflow_o         : sticky, a push arrived while full
// Modports: master = register file and core side, slave = the buffer.
interface iob_uart_txbuf_if
    import iob_uart_txbuf_pkg::*;
#(
    parameter int unsigned DATA_W     = DefaultDataW,
    parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2
);

    logic                  wr_en_i;
    logic [DATA_W-1:0]     wr_data_i;
    logic                  tx_en_i;
    logic                  tx_ready_i;
    logic                  clr_ovf_i;
    logic [DATA_W-1:0]     tx_data_o;
    logic                  tx_write_o;
    logic                  full_o;
    logic                  empty_o;
    logic [DEPTH_LOG2:0]   level_o;
    logic                  overflow_o;

    modport master (
        output wr_en_i, wr_data_i, tx_en_i, tx_ready_i, clr_ovf_i,
        input  tx_data_o, tx_write_o, full_o, empty_o, level_o, overflow_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, tx_en_i, tx_ready_i, clr_ovf_i,
        output tx_data_o, tx_write_o, full_o, empty_o, level_o, overflow_o
    );

endinterface

// File: rtl/iob_uart_txbuf_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read. No reset; contents
// are don't-care until written.
//   clk_i             : clock
//   we_i, waddr_i,    : write enable, address and data
//   wdata_i
//   raddr_i, rdata_o  : combinational read port
module iob_uart_txbuf_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/iob_uart_txbuf.sv
// Transmit buffer in front of the UART core. CPU bytes are queued in a circular
// FIFO and launched into the core one at a time with a one-cycle write strobe,
// only while the core reports ready and transmit is enabled.
//   clk_i      : system clock
//   arst_n_i   : asynchronous reset, active-low
//   rst_soft_i : synchronous soft reset, active-high, overrides every other input
//   bus        : register file / core bus (slave side), see iob_uart_txbuf_if
module iob_uart_txbuf
    import iob_uart_txbuf_pkg::*;
#(
    parameter int unsigned DATA_W     = DefaultDataW,
    parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 rst_soft_i,
    iob_uart_txbuf_if.slave      bus
);

    localparam logic [DEPTH_LOG2:0] LevelFull = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_q, empty_q, ovf_q, tx_write_q;
    logic [DATA_W-1:0]     tx_data_q, rd_data;
    state_e                state_q;

    logic push, launch, ovf_set;

    // Full and empty are the registered flags, so a push while full is dropped even
    // if a launch frees a slot on the same edge.
    assign push    = bus.wr_en_i & ~full_q;
    assign ovf_set = bus.wr_en_i & full_q;
    assign launch  = (state_q == StIdle) & ~empty_q & bus.tx_en_i & bus.tx_ready_i;

    always_comb begin
        level_d = level_q;
        if (push && !launch) begin
            level_d = level_q + 1'b1;
        end else if (!push && launch) begin
            level_d = level_q - 1'b1;
        end
    end

    iob_uart_txbuf_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            tx_write_q <= 1'b0;
            tx_data_q  <= '0;
            state_q    <= StIdle;
        end else if (rst_soft_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            tx_write_q <= 1'b0;
            tx_data_q  <= '0;
            state_q    <= StIdle;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            level_q <= level_d;
            full_q  <= (level_d == LevelFull);
            empty_q <= (level_d == '0);

            // A new overflow beats a clear on the same edge.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf_i) begin
                ovf_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (launch) begin
                        tx_data_q  <= rd_data;
                        tx_write_q <= 1'b1;
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        state_q    <= StWaitBusy;
                    end
                end
                // Core may still show ready right after the strobe; wait for it to
                // drop so the same idle window cannot trigger a second launch.
                StWaitBusy: begin
                    tx_write_q <= 1'b0;
                    if (!bus.tx_ready_i) begin
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (bus.tx_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    tx_write_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign bus.tx_data_o  = tx_data_q;
    assign bus.tx_write_o = tx_write_q;
    assign bus.full_o     = full_q;
    assign bus.empty_o    = empty_q;
    assign bus.level_o    = level_q;
    assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_iob_uart_txbuf.sv
module tb_iob_uart_txbuf;

    localparam int DW    = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic clk_i    = 1'b0;
    logic arst_n   = 1'b0;
    logic rst_soft = 1'b0;

    always #5 clk_i = ~clk_i;

    iob_uart_txbuf_if #(.DATA_W(DW), .DEPTH_LOG2(DL)) bus ();

    iob_uart_txbuf #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n),
        .rst_soft_i (rst_soft),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Core model: ready drops when a strobe is seen and stays low for a random hold.
    logic core_rdy    = 1'b1;
    logic ready_block = 1'b0;
    int   core_cnt    = 0;
    int   hold_min    = 1;
    int   hold_max    = 1;
    assign bus.tx_ready_i = core_rdy & ~ready_block;

    // Behavioural reference: a byte queue plus a record of where the core handshake
    // stands since the last launch.
    byte unsigned mq[$];
    bit           m_need_low, m_need_high, m_write, m_ovf;
    byte unsigned m_data;

    always @(posedge clk_i or negedge arst_n) begin
        bit full_pre, go;
        if (!arst_n || rst_soft) begin
            mq.delete();
            m_need_low  = 0;
            m_need_high = 0;
            m_write     = 0;
            m_data      = 0;
            m_ovf       = 0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            go = !m_need_low && !m_need_high && mq.size() > 0 &&
                 bus.tx_en_i && bus.tx_ready_i;
            if (go) begin
                m_data      = mq.pop_front();
                m_write     = 1;
                m_need_low  = 1;
            end else begin
                m_write = 0;
                if (m_need_low && !bus.tx_ready_i) begin
                    m_need_low  = 0;
                    m_need_high = 1;
                end else if (m_need_high && bus.tx_ready_i) begin
                    m_need_high = 0;
                end
            end
            if (bus.wr_en_i && !full_pre) mq.push_back(bus.wr_data_i);
            if (bus.wr_en_i && full_pre) m_ovf = 1;
            else if (bus.clr_ovf_i) m_ovf = 0;
        end
    end

    byte unsigned emitted[$];

    always @(negedge clk_i) begin
        if (arst_n) begin
            check("tx_write", bus.tx_write_o, m_write);
            check("tx_data",  bus.tx_data_o,  m_data);
            check("level",    bus.level_o,    mq.size());
            check("full",     bus.full_o,     mq.size() == DEPTH);
            check("empty",    bus.empty_o,    mq.size() == 0);
            check("overflow", bus.overflow_o, m_ovf);
            if (bus.tx_write_o) emitted.push_back(bus.tx_data_o);
        end
        if (arst_n && bus.tx_write_o) begin
            core_rdy = 1'b0;
            core_cnt = $urandom_range(hold_max, hold_min);
        end else if (!core_rdy) begin
            if (core_cnt <= 1) core_rdy = 1'b1;
            else core_cnt--;
        end
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic push_byte(input byte unsigned b);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = b;
        tick();
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic wait_emit(input string name, input int n, input int budget);
        int k = 0;
        while (emitted.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, emitted.size(), n);
    endtask

    task automatic fill_blocked(input byte unsigned base, input int n);
        ready_block = 1'b1;
        for (int i = 0; i < n; i++) push_byte(base + byte'(i));
        ready_block = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned sent[$];
        byte unsigned b;
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = '0;
        bus.tx_en_i   = 1'b0;
        bus.clr_ovf_i = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_level", bus.level_o, 0);
        check("rst_empty", bus.empty_o, 1);
        check("rst_full", bus.full_o, 0);
        check("rst_write", bus.tx_write_o, 0);
        check("rst_data", bus.tx_data_o, 0);
        check("rst_ovf", bus.overflow_o, 0);
        arst_n = 1'b1;
        tick();

        // Single byte: strobe one edge after the push
        bus.tx_en_i = 1'b1;
        emitted.delete();
        push_byte(8'hA5);
        check("single_level1", bus.level_o, 1);
        check("single_nostrobe", bus.tx_write_o, 0);
        tick();
        check("single_strobe", bus.tx_write_o, 1);
        check("single_data", bus.tx_data_o, 8'hA5);
        check("single_level0", bus.level_o, 0);
        check("single_empty", bus.empty_o, 1);
        tick();
        check("single_strobe_off", bus.tx_write_o, 0);
        check("single_data_hold", bus.tx_data_o, 8'hA5);
        repeat (5) tick();
        check("single_count", emitted.size(), 1);

        // Burst of 16 with a slow core
        hold_min = 20; hold_max = 20;
        emitted.delete();
        fill_blocked(8'h01, 16);
        check("burst_full", bus.full_o, 1);
        check("burst_level", bus.level_o, 16);
        wait_emit("burst_count", 16, 16 * 25 + 50);
        repeat (30) tick();
        check("burst_exact", emitted.size(), 16);
        for (int i = 0; i < 16 && i < emitted.size(); i++)
            check("burst_order", emitted[i], i + 1);

        // Overflow
        hold_min = 1; hold_max = 1;
        bus.tx_en_i = 1'b0;
        emitted.delete();
        for (int i = 0; i < 17; i++) push_byte(8'h30 + byte'(i));
        check("ovf_level", bus.level_o, 16);
        check("ovf_flag", bus.overflow_o, 1);
        bus.wr_en_i = 1'b1; bus.clr_ovf_i = 1'b1;
        tick();
        bus.wr_en_i = 1'b0; bus.clr_ovf_i = 1'b0;
        check("ovf_set_wins", bus.overflow_o, 1);
        bus.clr_ovf_i = 1'b1;
        tick();
        bus.clr_ovf_i = 1'b0;
        check("ovf_clear", bus.overflow_o, 0);
        bus.tx_en_i = 1'b1;
        wait_emit("ovf_drain", 16, 200);
        repeat (10) tick();
        check("ovf_no17th", emitted.size(), 16);
        for (int i = 0; i < 16 && i < emitted.size(); i++)
            check("ovf_order", emitted[i], 8'h30 + i);

        // Wrap-around with random gaps and busy times
        hold_min = 1; hold_max = 6;
        emitted.delete();
        for (int i = 0; i < 40; i++) begin
            int g = 0;
            while (bus.full_o && g < 200) begin tick(); g++; end
            b = 8'($urandom);
            sent.push_back(b);
            push_byte(b);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_emit("wrap_count", 40, 1000);
        for (int i = 0; i < 40 && i < emitted.size(); i++)
            check("wrap_order", emitted[i], sent[i]);
        repeat (10) tick();

        // Enable gating
        hold_min = 3; hold_max = 3;
        bus.tx_en_i = 1'b0;
        emitted.delete();
        push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
        bus.tx_en_i = 1'b1;
        wait_emit("gate_first", 1, 20);
        bus.tx_en_i = 1'b0;
        repeat (30) tick();
        check("gate_blocked", emitted.size(), 1);
        check("gate_kept", bus.level_o, 2);
        bus.tx_en_i = 1'b1;
        wait_emit("gate_rest", 3, 60);
        for (int i = 0; i < 3 && i < emitted.size(); i++)
            check("gate_order", emitted[i], 8'hC1 + i);
        repeat (10) tick();

        // Soft reset in WAIT_DONE with 5 bytes queued
        hold_min = 20; hold_max = 20;
        emitted.delete();
        fill_blocked(8'h60, 6);
        wait_emit("srst_launch", 1, 10);
        repeat (2) tick();
        check("srst_pre_level", bus.level_o, 5);
        rst_soft = 1'b1;
        tick();
        rst_soft = 1'b0;
        check("srst_level", bus.level_o, 0);
        check("srst_empty", bus.empty_o, 1);
        check("srst_write", bus.tx_write_o, 0);
        check("srst_data", bus.tx_data_o, 0);
        repeat (25) tick();
        push_byte(8'h77);
        tick();
        check("srst_idle_launch", bus.tx_write_o, 1);
        check("srst_idle_data", bus.tx_data_o, 8'h77);
        repeat (30) tick();

        // Asynchronous reset between edges, right while a strobe is up
        emitted.delete();
        fill_blocked(8'h50, 6);
        wait_emit("arst_launch", 1, 10);
        #2 arst_n = 1'b0;
        #1;
        check("arst_write", bus.tx_write_o, 0);
        check("arst_data", bus.tx_data_o, 0);
        check("arst_level", bus.level_o, 0);
        check("arst_empty", bus.empty_o, 1);
        check("arst_full", bus.full_o, 0);
        #1 arst_n = 1'b1;
        repeat (30) tick();

        // Random traffic against the model
        hold_min = 1; hold_max = 4;
        for (int c = 0; c < 600; c++) begin
            bus.wr_en_i   = ($urandom_range(0, 1) == 1);
            bus.wr_data_i = 8'($urandom);
            bus.tx_en_i   = ($urandom_range(0, 9) < 8);
            bus.clr_ovf_i = ($urandom_range(0, 19) == 0);
            ready_block   = ($urandom_range(0, 9) == 0);
            rst_soft      = ($urandom_range(0, 99) == 0);
            tick();
        end
        bus.wr_en_i = 1'b0; bus.clr_ovf_i = 1'b0; ready_block = 1'b0; rst_soft = 1'b0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
